// File: rtl/rx_fifo_buff.sv
// ============================================================================
// rx_fifo_buff : RX byte FIFO with per-byte end-of-frame tags and frame count
// Revision     : 1.0
// ============================================================================
`default_nettype none

module rx_fifo_buff #(
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       write,
   input  logic [7:0] data_in,
   input  logic       rx_mac_last,
   input  logic       read,
   output logic [7:0] data_out,
   output logic       empty,
   output logic       full,
   output logic       tx_valid_flag
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   logic [7:0]        mem_data [DEPTH];
   logic [DEPTH-1:0]  tag_bits;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   byte_cnt;
   logic [ADDR_W:0]   frame_cnt;

   logic              wr_ok;
   logic              rd_ok;
   logic              close_frame;
   logic              fr_inc;
   logic              fr_dec;
   logic [ADDR_W-1:0] wr_prev;

   assign empty         = (byte_cnt == '0);
   assign full          = (byte_cnt == DEPTH_CNT);
   assign tx_valid_flag = (frame_cnt != '0);

   assign wr_ok       = write & ~full;
   assign rd_ok       = read & ~empty;
   // A last byte that cannot be stored still terminates the frame: retag the newest entry.
   assign close_frame = write & full & rx_mac_last;
   assign wr_prev     = wr_ptr - 1'b1;
   assign fr_inc      = (wr_ok & rx_mac_last) | close_frame;
   assign fr_dec      = rd_ok & tag_bits[rd_ptr];

   // Storage is deliberately left out of reset; requests are discarded during rst.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem_data[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_ok) begin
            tag_bits[wr_ptr] <= rx_mac_last;
         end else if (close_frame) begin
            tag_bits[wr_prev] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         byte_cnt  <= '0;
         frame_cnt <= '0;
         data_out  <= 8'h00;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_out <= mem_data[rd_ptr];
         end

         case ({wr_ok, rd_ok})
            2'b10:   byte_cnt <= byte_cnt + 1'b1;
            2'b01:   byte_cnt <= byte_cnt - 1'b1;
            default: byte_cnt <= byte_cnt;
         endcase

         case ({fr_inc, fr_dec})
            2'b10:   if (frame_cnt != DEPTH_CNT) frame_cnt <= frame_cnt + 1'b1;
            2'b01:   frame_cnt <= frame_cnt - 1'b1;
            default: frame_cnt <= frame_cnt;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rx_fifo_buff.sv
// ============================================================================
// tb_rx_fifo_buff : scoreboard bench for rx_fifo_buff
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_rx_fifo_buff;

   localparam int DEPTH  = 2048;
   localparam int ADDR_W = 11;

   logic       clk = 1'b0;
   logic       rst;
   logic       write;
   logic [7:0] data_in;
   logic       rx_mac_last;
   logic       read;
   logic [7:0] data_out;
   logic       empty;
   logic       full;
   logic       tx_valid_flag;

   logic [8:0] mq[$];      // model contents {tag, byte}
   logic [7:0] exp_q[$];   // scoreboard of expected read data
   int         mframes;
   logic       rd_expect;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   rx_fifo_buff #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .write         (write),
      .data_in       (data_in),
      .rx_mac_last   (rx_mac_last),
      .read          (read),
      .data_out      (data_out),
      .empty         (empty),
      .full          (full),
      .tx_valid_flag (tx_valid_flag)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Issue one cycle of stimulus, update the model, then check the flags.
   task automatic step(input logic w, input logic [7:0] d, input logic l,
                       input logic r, input logic rs);
      int         sz;
      logic [8:0] e;
      write = w; data_in = d; rx_mac_last = l; read = r; rst = rs;
      rd_expect = 1'b0;
      if (rs) begin
         mq.delete();
         mframes = 0;
      end else begin
         sz = mq.size();
         if (r && sz > 0) begin
            e = mq.pop_front();
            exp_q.push_back(e[7:0]);
            rd_expect = 1'b1;
            if (e[8]) mframes--;
         end
         if (w && sz < DEPTH) begin
            mq.push_back({l, d});
            if (l) mframes++;
         end else if (w && l && sz == DEPTH) begin
            e = mq[mq.size()-1];
            e[8] = 1'b1;
            mq[mq.size()-1] = e;
            mframes++;
         end
      end
      @(posedge clk);
      #1;
      write = 1'b0; read = 1'b0; rx_mac_last = 1'b0; rst = 1'b0; rd_expect = 1'b0;
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("tx_valid_flag", 32'(tx_valid_flag), 32'(mframes != 0));
   endtask

   // Monitor: a read accepted on an edge presents data_out afterwards.
   initial begin
      logic       f;
      logic [7:0] x;
      forever begin
         @(posedge clk);
         f = rd_expect;
         @(negedge clk);
         if (f) begin
            if (exp_q.size() == 0) begin
               chk("monitor_unexpected_read", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               x = exp_q.pop_front();
               chk("data_out", 32'(data_out), 32'(x));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: timeout got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; write = 1'b0; read = 1'b0; data_in = 8'h00; rx_mac_last = 1'b0;
      rd_expect = 1'b0; mframes = 0;
      #2;

      // Reset state
      step(0, 8'h00, 0, 0, 1);
      chk("reset_data_out", 32'(data_out), 32'h00);
      chk("reset_empty", 32'(empty), 32'd1);

      // Three-byte frame
      step(1, 8'hA1, 0, 0, 0);
      chk("empty_after_A1", 32'(empty), 32'd0);
      chk("txv_after_A1", 32'(tx_valid_flag), 32'd0);
      step(1, 8'hB2, 0, 0, 0);
      chk("txv_after_B2", 32'(tx_valid_flag), 32'd0);
      step(1, 8'hC3, 1, 0, 0);
      chk("txv_after_C3", 32'(tx_valid_flag), 32'd1);
      step(0, 8'h00, 0, 1, 0);
      chk("rd1_A1", 32'(data_out), 32'hA1);
      step(0, 8'h00, 0, 1, 0);
      chk("rd2_B2", 32'(data_out), 32'hB2);
      step(0, 8'h00, 0, 1, 0);
      chk("rd3_C3", 32'(data_out), 32'hC3);
      chk("txv_after_rd3", 32'(tx_valid_flag), 32'd0);
      chk("empty_after_rd3", 32'(empty), 32'd1);
      step(0, 8'h00, 0, 1, 0);
      chk("read_on_empty_holds", 32'(data_out), 32'hC3);

      // Fill to DEPTH, then a dropped last byte closes the frame
      for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0, 0, 0);
      chk("full_at_depth", 32'(full), 32'd1);
      chk("txv_no_frame_yet", 32'(tx_valid_flag), 32'd0);
      step(1, 8'h5A, 1, 0, 0);
      chk("full_after_drop", 32'(full), 32'd1);
      chk("txv_after_drop", 32'(tx_valid_flag), 32'd1);
      for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 0, 1, 0);
      chk("last_byte_of_fill", 32'(data_out), 32'hFF);
      chk("txv_after_drain", 32'(tx_valid_flag), 32'd0);

      // Simultaneous read+write with two bytes stored
      step(1, 8'h31, 0, 0, 0);
      step(1, 8'h32, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 8'h40 + 8'(i), 0, 1, 0);
      chk("rw_not_empty", 32'(empty), 32'd0);
      step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 0, 1, 0);
      chk("rw_tail_49", 32'(data_out), 32'h49);
      chk("rw_empty_after", 32'(empty), 32'd1);

      // Interleaved traffic wrapping both pointers
      for (int i = 0; i < DEPTH + 5; i++)
         step(1, 8'(i * 7), (i % 100) == 99, (i % 2) == 1, 0);
      while (mq.size() > 0) step(0, 8'h00, 0, 1, 0);
      chk("wrap_txv_zero", 32'(tx_valid_flag), 32'd0);

      // Reset mid-frame with 5 bytes stored and requests pending
      for (int i = 0; i < 5; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
      step(1, 8'h7A, 1, 1, 0);
      chk("pre_reset_data", 32'(data_out), 32'h70);
      step(1, 8'h7B, 1, 1, 1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_txv", 32'(tx_valid_flag), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'h00);
      step(1, 8'hE5, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);
      chk("post_reset_byte", 32'(data_out), 32'hE5);
      chk("post_reset_txv", 32'(tx_valid_flag), 32'd0);

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rx_fifo_buff.md
RX_FIFO_BUFF -- requirements
Module: rx_fifo_buff

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning number of byte entries (power of two, >= 4).
REQ-002 SHALL have parameter ADDR_W, default 11, meaning log2(DEPTH).
REQ-003 SHALL use one clock and a synchronous, active-high reset; all logic is clocked on the rising edge of clk.
REQ-004 SHALL have port clk, input, 1, the single clock (RX MAC byte clock).
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port write, input, 1, write request for data_in (RX MAC valid).
REQ-007 SHALL have port data_in, input, 8, received frame byte.
REQ-008 SHALL have port rx_mac_last, input, 1, qualifies a write as the last byte of a frame.
REQ-009 SHALL have port read, input, 1, read request (TX side pops one byte).
REQ-010 SHALL have port data_out, output, 8, registered read data.
REQ-011 SHALL have port empty, output, 1, no unread bytes stored.
REQ-012 SHALL have port full, output, 1, DEPTH unread bytes stored.
REQ-013 SHALL have port tx_valid_flag, output, 1, at least one complete frame stored.

Function
REQ-014 SHALL store each entry as 9 bits: data_in plus an end-of-frame tag equal to rx_mac_last.
REQ-015 SHALL accept a write only when write=1 and full=0: store at wr_ptr, then wr_ptr+1 modulo DEPTH.
REQ-016 SHALL accept a read only when read=1 and empty=0: data_out <= data at rd_ptr on that edge (1-cycle latency), then rd_ptr+1 modulo DEPTH.
REQ-017 SHALL hold data_out unchanged on any cycle without an accepted read.
REQ-018 SHALL ignore a write while full; no state changes except as in REQ-022.
REQ-019 SHALL ignore a read while empty; data_out and pointers unchanged.
REQ-020 SHALL keep a byte count 0..DEPTH (ADDR_W+1 bits): +1 on an accepted write only, -1 on an accepted read only, unchanged when both are accepted in the same cycle.
REQ-021 SHALL derive empty = (count==0) and full = (count==DEPTH) as registered or combinational functions of the count, valid in the cycle after the update edge.
REQ-022 SHALL, when a write with rx_mac_last=1 is dropped because full=1, set the tag of entry wr_ptr-1 (modulo DEPTH) to 1 so the truncated frame is closed; the frame count is incremented as if the write had been accepted.
REQ-023 SHALL keep a frame count 0..DEPTH: +1 on an accepted write with rx_mac_last=1 (or on REQ-022), -1 on an accepted read whose entry tag is 1, unchanged when both occur in the same cycle.
REQ-024 SHALL drive tx_valid_flag = (frame count != 0), updated in the cycle after the counting edge.
REQ-025 SHALL allow an accepted write and an accepted read in the same cycle, including when read and write address the same wrap position; a read never returns the byte written in that same cycle.
REQ-026 SHALL wrap both pointers from DEPTH-1 to 0 without disturbing count, flags or data.

Reset
REQ-027 SHALL, on clk edge with rst=1, set wr_ptr=0, rd_ptr=0, byte count=0, frame count=0, data_out=8'h00, empty=1, full=0, tx_valid_flag=0; memory contents are not cleared.
REQ-028 SHALL give rst priority over simultaneous read/write; requests in the reset cycle are discarded, including mid-frame.

Verification
REQ-029 SHALL pass: reset, write 8'hA1,8'hB2,8'hC3 with rx_mac_last on 8'hC3 -> empty=0 after first write, tx_valid_flag=1 only after the C3 edge.
REQ-030 SHALL pass: then read 3 cycles -> data_out A1,B2,C3 one cycle after each read edge, tx_valid_flag=0 and empty=1 after the third read; a further read leaves data_out=C3.
REQ-031 SHALL pass: DEPTH writes without last, one more write with rx_mac_last=1 -> full=1, byte count stays DEPTH, tx_valid_flag=1, and reading all DEPTH bytes yields the tag on the final byte, leaving tx_valid_flag=0.
REQ-032 SHALL pass: with 2 bytes stored, simultaneous read+write for 10 cycles -> count stays 2, data order preserved.
REQ-033 SHALL pass: write DEPTH+5 bytes interleaved with reads so pointers wrap -> data returned in write order, no corruption at 2047->0.
REQ-034 SHALL pass: rst asserted mid-frame with 5 bytes stored -> next cycle empty=1, full=0, tx_valid_flag=0, data_out=8'h00.
